// File: rtl/spi_target.sv
// rtl/spi_target.sv - SPI responder: oversampled pins, 8-bit MSB-first frames, rx stream, one-entry tx buffer
module spi_target #(
    parameter bit         CPOL        = 1'b0,
    parameter bit         CPHA        = 1'b0,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck_i,
    input  logic       cs_n_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe,
    output logic [7:0] rx_dat,
    output logic       rx_vld,
    input  logic       rx_rdy,
    input  logic [7:0] tx_dat,
    input  logic       tx_vld,
    output logic       tx_rdy,
    output logic       busy,
    output logic       rx_ovr,
    output logic       tx_unf,
    output logic       abort
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sck_prev_q;

    state_e state_q, state_d;
    logic   activate, deactivate;

    logic [7:0] rx_shift_q, rx_shift_d;
    logic [2:0] rx_cnt_q, rx_cnt_d;
    logic       rx_done_q, rx_done_d;
    logic [7:0] rx_dat_q, rx_dat_d;
    logic       rx_vld_q, rx_vld_d;
    logic       rx_ovr_q, rx_ovr_d;

    logic [7:0] tx_shift_q, tx_shift_d;
    logic [2:0] tx_cnt_q, tx_cnt_d;
    logic [7:0] tx_buf_q, tx_buf_d;
    logic       tx_full_q, tx_full_d;
    logic       tx_unf_q, tx_unf_d;
    logic       abort_q, abort_d;
    logic       load;

    logic sck_s, cs_s, mosi_s;
    logic sck_edge, lead_edge, trail_edge, in_frame, sample_edge, shift_edge;

    // Pin synchronizers; all three share one depth so data stays aligned with its clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_q  <= {SYNC_STAGES{CPOL}};
            cs_sync_q   <= {SYNC_STAGES{1'b1}};
            mosi_sync_q <= '0;
            sck_prev_q  <= CPOL;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
        end
    end

    assign sck_s      = sck_sync_q[SYNC_STAGES-1];
    assign cs_s       = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    assign sck_edge   = sck_s ^ sck_prev_q;
    assign lead_edge  = sck_edge & (sck_prev_q == CPOL);
    assign trail_edge = sck_edge & (sck_s == CPOL);
    // Edges only count while selected and not in the cycle the frame ends
    assign in_frame    = (state_q == ST_ACTIVE) & ~cs_s;
    assign sample_edge = in_frame & (CPHA ? trail_edge : lead_edge);
    assign shift_edge  = in_frame & (CPHA ? lead_edge : trail_edge);

    // Frame state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame next-state and select-derived outputs
    always_comb begin
        state_d    = state_q;
        activate   = 1'b0;
        deactivate = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!cs_s) begin
                    state_d  = ST_ACTIVE;
                    activate = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cs_s) begin
                    state_d    = ST_IDLE;
                    deactivate = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy    = (state_q == ST_ACTIVE);
        miso_oe = (state_q == ST_ACTIVE);
    end

    // Shift registers, rx stream, tx buffer and event pulses
    always_comb begin
        rx_shift_d = rx_shift_q;
        rx_cnt_d   = rx_cnt_q;
        rx_done_d  = 1'b0;
        rx_dat_d   = rx_dat_q;
        rx_vld_d   = rx_vld_q;
        rx_ovr_d   = 1'b0;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        tx_buf_d   = tx_buf_q;
        tx_full_d  = tx_full_q;
        tx_unf_d   = 1'b0;
        abort_d    = 1'b0;
        load       = 1'b0;

        if (deactivate) begin
            // Partial rx byte and the tx byte in flight are dropped; buffer and rx_vld survive
            rx_shift_d = '0;
            rx_cnt_d   = '0;
            tx_shift_d = '0;
            tx_cnt_d   = '0;
            abort_d    = (rx_cnt_q != 3'd0) | (CPHA & (tx_cnt_q != 3'd0));
        end else begin
            if (sample_edge) begin
                rx_shift_d = {rx_shift_q[6:0], mosi_s};
                rx_cnt_d   = rx_cnt_q + 3'd1;
                rx_done_d  = (rx_cnt_q == 3'd7);
            end
            if (activate && !CPHA) begin
                load = 1'b1;
            end
            if (shift_edge) begin
                if (tx_cnt_q == (CPHA ? 3'd0 : 3'd7)) begin
                    load = 1'b1;
                end else begin
                    tx_shift_d = {tx_shift_q[6:0], 1'b0};
                end
                tx_cnt_d = tx_cnt_q + 3'd1;
            end
        end

        // A completed byte is published one cycle later unless the consumer is stalled
        if (rx_done_q) begin
            if (rx_vld_q && !rx_rdy) begin
                rx_ovr_d = 1'b1;
            end else begin
                rx_dat_d = rx_shift_q;
                rx_vld_d = 1'b1;
            end
        end else if (rx_vld_q && rx_rdy) begin
            rx_vld_d = 1'b0;
        end

        // Load sees the buffer as it was before this cycle's write, so there is no bypass
        if (load) begin
            if (tx_full_q) begin
                tx_shift_d = tx_buf_q;
                tx_full_d  = 1'b0;
            end else begin
                tx_shift_d = IDLE_BYTE;
                tx_unf_d   = 1'b1;
            end
        end
        if (tx_vld && !tx_full_q) begin
            tx_buf_d  = tx_dat;
            tx_full_d = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_shift_q <= '0;
            rx_cnt_q   <= '0;
            rx_done_q  <= 1'b0;
            rx_dat_q   <= '0;
            rx_vld_q   <= 1'b0;
            rx_ovr_q   <= 1'b0;
            tx_shift_q <= '0;
            tx_cnt_q   <= '0;
            tx_buf_q   <= '0;
            tx_full_q  <= 1'b0;
            tx_unf_q   <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            rx_shift_q <= rx_shift_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_done_q  <= rx_done_d;
            rx_dat_q   <= rx_dat_d;
            rx_vld_q   <= rx_vld_d;
            rx_ovr_q   <= rx_ovr_d;
            tx_shift_q <= tx_shift_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_buf_q   <= tx_buf_d;
            tx_full_q  <= tx_full_d;
            tx_unf_q   <= tx_unf_d;
            abort_q    <= abort_d;
        end
    end

    assign miso_o = tx_shift_q[7];
    assign rx_dat = rx_dat_q;
    assign rx_vld = rx_vld_q;
    assign tx_rdy = ~tx_full_q;
    assign rx_ovr = rx_ovr_q;
    assign tx_unf = tx_unf_q;
    assign abort  = abort_q;

endmodule
